sent_tx_frame_ctrl: RTL and testbench
=====================================

Name: sent_tx_frame_ctrl

Overview:
- Frame sequencer directly upstream of the SENT TX pulse generator.
- Accepts one status nibble plus up to six data nibbles per frame, computes the SAE J2716 CRC-4, and drives the generator's one-hot controls (sync/pulse/pause/idle) and its nibble bus.
- Advances one SENT field per `pulse_done_i` from the generator.
- Retransmits the last accepted frame while enabled and no new data is offered.

Parameters:
- NUM_DATA_NIBBLES, 6, data nibbles per frame (1..6); sent MSB nibble first.
- CRC_SEED, 4'h5, CRC-4 initial value.

Ports:
- clk_tx  input  1  system clock
- reset_tx  input  1  asynchronous, active-high reset
- enable_i  input  1  transmit enable; sampled at frame boundaries
- status_i  input  4  status/communication nibble
- data_i  input  4*NUM_DATA_NIBBLES  data nibbles; [MSB nibble] sent first
- data_valid_i  input  1  new frame offered
- data_ready_o  output  1  one-cycle pulse: status_i/data_i latched this cycle
- pulse_done_i  input  1  one-cycle done pulse from the pulse generator
- data_nibble_o  output  4  nibble value for the current pulse
- sync_o  output  1  sync field active
- pulse_o  output  1  status/data/CRC field active
- pause_o  output  1  pause field active (macro-dependent)
- idle_o  output  1  line idle request
- crc_o  output  4  CRC of the current frame
- frame_done_o  output  1  one-cycle pulse at end of the last field

Behaviour:
- Reset (async, immediate, mid-frame included):
  - state=IDLE, idle_o=1.
  - sync_o, pulse_o, pause_o, data_nibble_o, crc_o, data_ready_o, frame_done_o all 0.
  - Latched frame cleared to 0.
- All outputs are registered. sync_o/pulse_o/pause_o/idle_o are one-hot at all times.
- States: IDLE, SYNC, STATUS, DATA, CRC, PAUSE.
- IDLE:
  - If enable_i && data_valid_i: latch inputs, pulse data_ready_o, go to SYNC next cycle.
  - enable_i alone with no frame ever latched stays in IDLE.
  - enable_i with a previously latched frame goes to SYNC and resends it.
- SYNC: sync_o=1, data_nibble_o=0.
- STATUS: pulse_o=1, data_nibble_o=status.
- DATA: pulse_o=1, data_nibble_o=nibble[idx]; idx counts 0..NUM_DATA_NIBBLES-1.
- CRC: pulse_o=1, data_nibble_o=crc.
- PAUSE: pause_o=1, data_nibble_o=0.
- Transitions:
  - Each state holds its outputs until pulse_done_i=1.
  - The next state's outputs appear on the following clk_tx edge; control is never dropped for more than one cycle between fields.
  - pulse_done_i in IDLE is ignored.
- CRC:
  - Polynomial x^4+x^3+x^2+1; seed CRC_SEED.
  - Per nibble: crc = T[crc] ^ nibble, where T[x] = (x<<4) mod poly.
  - After the last nibble, one augmenting zero-nibble step: crc = T[crc].
  - Computed serially, one nibble per clk_tx, starting the cycle after latch. Done within NUM_DATA_NIBBLES+1 cycles, always before SYNC ends.
  - crc_o is valid from the SYNC-exit cycle and holds until the next latch.
  - Status nibble is excluded from the CRC.
- End of frame (pulse_done_i in the last field):
  - frame_done_o=1 for one cycle.
  - Then: enable_i && data_valid_i → latch + data_ready_o, SYNC.
  - enable_i only → SYNC, resend the latched frame with the same CRC.
  - Otherwise → IDLE.
- enable_i deasserted mid-frame: the frame completes, then IDLE.
- data_valid_i mid-frame: ignored; data_ready_o is only issued at boundaries.

Optional Feature:
- SENT_TX_PAUSE_EN defined:
  - PAUSE state follows CRC; frame_done_o fires on pulse_done_i in PAUSE.
- Not defined:
  - PAUSE state and pause_o logic removed; pause_o tied 0.
  - frame_done_o fires on pulse_done_i in CRC; CRC goes directly to SYNC/IDLE.

Decomposition:
- Shared package sent_pkg:
  - state enum.
  - CRC_POLY (5'b11101), CRC_SEED default, MAX_DATA_NIBBLES=6.
  - CRC-4 table function T.
- One sub-module: sent_crc4_serial (seed load, one nibble per cycle, augment step, done flag).

Test Plan:
- Reset then enable_i=1, data_valid_i=1, data_i=24'h000000, status 4'h0, pulse model returns done after 8 cycles per field:
  - data_ready_o pulses once.
  - Field order SYNC, STATUS, 6×DATA, CRC, PAUSE.
  - crc_o=4'h5.
  - frame_done_o pulses once.
- data_i=24'h123456, status 4'hA:
  - data_nibble_o sequence A,1,2,3,4,5,6,crc.
  - crc_o matches the reference-model table computation.
- enable_i held, data_valid_i dropped after the first frame: second frame identical, no data_ready_o.
- enable_i dropped during DATA field 3: frame completes, then idle_o=1 and all other controls 0.
- reset_tx asserted during CRC field: outputs return to reset values asynchronously; no frame_done_o.
- Build without SENT_TX_PAUSE_EN: pause_o never asserts; frame_done_o coincides with the CRC done pulse; back-to-back SYNC next cycle.

Source files
------------

// File: rtl/sent_pkg.sv
// Shared types, constants and the CRC-4 table function for the SENT TX frame path.
package sent_pkg;

   // Frame sequencer states, one per SENT field plus idle.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_STATUS = 3'd2,
      ST_DATA   = 3'd3,
      ST_CRC    = 3'd4,
      ST_PAUSE  = 3'd5
   } sent_state_t;

   localparam logic [4:0] CRC_POLY         = 5'b11101;   // x^4+x^3+x^2+1
   localparam logic [3:0] CRC_SEED         = 4'h5;
   localparam int         MAX_DATA_NIBBLES = 6;

   // T[x] = (x << 4) mod poly, computed as four single-bit polynomial shifts.
   function automatic logic [3:0] crc4_t(input logic [3:0] x);
      logic [4:0] v;
      v = {1'b0, x};
      for (int i = 0; i < 4; i++) begin
         v = v << 1;
         if (v[4]) v = v ^ CRC_POLY;
      end
      return v[3:0];
   endfunction

endpackage

// File: rtl/sent_crc4_serial.sv
// Serial SENT CRC-4: loads the seed on start, folds in one data nibble per
// clock (MSB nibble first), then applies one augmenting zero-nibble step and
// pulses done_o for one cycle with the final value on crc_o.
module sent_crc4_serial
   import sent_pkg::*;
#(
   parameter int         NUM_DATA_NIBBLES = 6,
   parameter logic [3:0] SEED             = CRC_SEED
) (
   input  logic                            clk_tx,
   input  logic                            reset_tx,
   input  logic                            start_i,
   input  logic [4*NUM_DATA_NIBBLES-1:0]   data_i,
   output logic [3:0]                      crc_o,
   output logic                            done_o
);

   logic [4*NUM_DATA_NIBBLES-1:0] shift_reg;
   logic [2:0]                    cnt_reg;
   logic                          busy_reg;

   // Walk the latched nibbles one per cycle; the final step is the zero augment.
   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) begin
         crc_o     <= 4'h0;
         shift_reg <= '0;
         cnt_reg   <= 3'd0;
         busy_reg  <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (start_i) begin
            crc_o     <= SEED;
            shift_reg <= data_i;
            cnt_reg   <= 3'(NUM_DATA_NIBBLES);
            busy_reg  <= 1'b1;
         end else if (busy_reg) begin
            if (cnt_reg != 3'd0) begin
               crc_o     <= crc4_t(crc_o) ^ shift_reg[4*NUM_DATA_NIBBLES-1 -: 4];
               shift_reg <= shift_reg << 4;
               cnt_reg   <= cnt_reg - 3'd1;
            end else begin
               crc_o    <= crc4_t(crc_o);
               busy_reg <= 1'b0;
               done_o   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sent_tx_frame_ctrl.sv
// SENT TX frame sequencer: latches status + data nibbles, runs the serial
// CRC-4 and steps the pulse generator through SYNC/STATUS/DATA/CRC fields,
// one field per pulse_done_i. Resends the last frame while enabled.
// Optional pause field: define SENT_TX_PAUSE_EN to insert PAUSE after CRC.
module sent_tx_frame_ctrl
   import sent_pkg::*;
#(
   parameter int         NUM_DATA_NIBBLES = 6,
   parameter logic [3:0] CRC_SEED         = sent_pkg::CRC_SEED
) (
   input  logic                            clk_tx,
   input  logic                            reset_tx,
   input  logic                            enable_i,
   input  logic [3:0]                      status_i,
   input  logic [4*NUM_DATA_NIBBLES-1:0]   data_i,
   input  logic                            data_valid_i,
   output logic                            data_ready_o,
   input  logic                            pulse_done_i,
   output logic [3:0]                      data_nibble_o,
   output logic                            sync_o,
   output logic                            pulse_o,
   output logic                            pause_o,
   output logic                            idle_o,
   output logic [3:0]                      crc_o,
   output logic                            frame_done_o
);

   localparam int IDX_W = $clog2(MAX_DATA_NIBBLES);

   sent_state_t                   state_reg, state_next;
   logic [IDX_W-1:0]              idx_reg, idx_next;
   logic [4*NUM_DATA_NIBBLES-1:0] data_reg;
   logic [3:0]                    status_reg;
   logic                          have_frame_reg;
   logic                          latch, frame_end;
   logic [3:0]                    nibble_next;
   logic [3:0]                    crc_result;
   logic                          crc_done;
   logic [3:0]                    nib_arr [NUM_DATA_NIBBLES];

   // Split the latched word into nibbles, index 0 = MSB nibble (sent first).
   for (genvar gi = 0; gi < NUM_DATA_NIBBLES; gi++) begin : g_nib
      assign nib_arr[gi] = data_reg[4*(NUM_DATA_NIBBLES-1-gi) +: 4];
   end

   sent_crc4_serial #(
      .NUM_DATA_NIBBLES (NUM_DATA_NIBBLES),
      .SEED             (CRC_SEED)
   ) u_crc (
      .clk_tx   (clk_tx),
      .reset_tx (reset_tx),
      .start_i  (latch),
      .data_i   (data_i),
      .crc_o    (crc_result),
      .done_o   (crc_done)
   );

   // Field sequencing; frame boundaries decide between new data, resend or idle.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      latch      = 1'b0;
      frame_end  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (enable_i && data_valid_i) begin
               latch      = 1'b1;
               state_next = ST_SYNC;
            end else if (enable_i && have_frame_reg) begin
               state_next = ST_SYNC;
            end
         end
         ST_SYNC:   if (pulse_done_i) state_next = ST_STATUS;
         ST_STATUS: begin
            if (pulse_done_i) begin
               state_next = ST_DATA;
               idx_next   = '0;
            end
         end
         ST_DATA: begin
            if (pulse_done_i) begin
               if (idx_reg == IDX_W'(NUM_DATA_NIBBLES-1)) state_next = ST_CRC;
               else                                      idx_next   = idx_reg + 1'b1;
            end
         end
`ifdef SENT_TX_PAUSE_EN
         ST_CRC:   if (pulse_done_i) state_next = ST_PAUSE;
         ST_PAUSE: if (pulse_done_i) frame_end  = 1'b1;
`else
         ST_CRC:   if (pulse_done_i) frame_end  = 1'b1;
`endif
         default:  state_next = ST_IDLE;
      endcase
      if (frame_end) begin
         if (enable_i && data_valid_i) begin
            latch      = 1'b1;
            state_next = ST_SYNC;
         end else if (enable_i) begin
            state_next = ST_SYNC;
         end else begin
            state_next = ST_IDLE;
         end
      end
   end

   // Nibble value presented with the upcoming field.
   always_comb begin
      nibble_next = 4'h0;
      case (state_next)
         ST_STATUS: nibble_next = status_reg;
         ST_DATA:   nibble_next = nib_arr[idx_next];
         ST_CRC:    nibble_next = crc_o;
         default:   nibble_next = 4'h0;
      endcase
   end

   // State register and registered one-hot controls derived from the next state.
   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         sync_o        <= 1'b0;
         pulse_o       <= 1'b0;
         idle_o        <= 1'b1;
         data_nibble_o <= 4'h0;
         data_ready_o  <= 1'b0;
         frame_done_o  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         sync_o        <= (state_next == ST_SYNC);
         pulse_o       <= (state_next == ST_STATUS) || (state_next == ST_DATA) ||
                          (state_next == ST_CRC);
         idle_o        <= (state_next == ST_IDLE);
         data_nibble_o <= nibble_next;
         data_ready_o  <= latch;
         frame_done_o  <= frame_end;
      end
   end

`ifdef SENT_TX_PAUSE_EN
   // Pause control follows the next state like the other controls.
   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) pause_o <= 1'b0;
      else          pause_o <= (state_next == ST_PAUSE);
   end
`else
   assign pause_o = 1'b0;
`endif

   // Frame latch and CRC capture; crc_o holds until the next frame's CRC completes.
   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) begin
         data_reg       <= '0;
         status_reg     <= 4'h0;
         have_frame_reg <= 1'b0;
         crc_o          <= 4'h0;
      end else begin
         if (latch) begin
            data_reg       <= data_i;
            status_reg     <= status_i;
            have_frame_reg <= 1'b1;
         end
         if (crc_done) crc_o <= crc_result;
      end
   end

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// Directed bench for sent_tx_frame_ctrl with an 8-cycle-per-field pulse model.
module tb_sent_tx_frame_ctrl;

   localparam logic [3:0] C_SYNC  = 4'b1000;   // {sync, pulse, pause, idle}
   localparam logic [3:0] C_PULSE = 4'b0100;
   localparam logic [3:0] C_PAUSE = 4'b0010;
   localparam logic [3:0] C_IDLE  = 4'b0001;

   logic        clk_tx       = 1'b0;
   logic        reset_tx     = 1'b1;
   logic        enable_i     = 1'b0;
   logic [3:0]  status_i     = 4'h0;
   logic [23:0] data_i       = 24'h0;
   logic        data_valid_i = 1'b0;
   logic        pulse_done_i = 1'b0;
   logic        data_ready_o, sync_o, pulse_o, pause_o, idle_o, frame_done_o;
   logic [3:0]  data_nibble_o, crc_o;

   int tests = 0, fails = 0;
   int rdy_cnt = 0, done_cnt = 0, pause_cnt = 0;

   sent_tx_frame_ctrl #(.NUM_DATA_NIBBLES(6), .CRC_SEED(4'h5)) dut (
      .clk_tx        (clk_tx),
      .reset_tx      (reset_tx),
      .enable_i      (enable_i),
      .status_i      (status_i),
      .data_i        (data_i),
      .data_valid_i  (data_valid_i),
      .data_ready_o  (data_ready_o),
      .pulse_done_i  (pulse_done_i),
      .data_nibble_o (data_nibble_o),
      .sync_o        (sync_o),
      .pulse_o       (pulse_o),
      .pause_o       (pause_o),
      .idle_o        (idle_o),
      .crc_o         (crc_o),
      .frame_done_o  (frame_done_o)
   );

   always #5 clk_tx = ~clk_tx;

   // Pulse counters sampled on the inactive edge.
   always @(negedge clk_tx) begin
      if (data_ready_o) rdy_cnt++;
      if (frame_done_o) done_cnt++;
      if (pause_o)      pause_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check the field now presented, hold it 8 cycles, then return done.
   task automatic field(input string tag, input logic [3:0] ctl, input logic [3:0] nib);
      chk({tag, " ctl"}, {28'h0, sync_o, pulse_o, pause_o, idle_o}, {28'h0, ctl});
      chk({tag, " nib"}, {28'h0, data_nibble_o}, {28'h0, nib});
      repeat (7) @(negedge clk_tx);
      pulse_done_i = 1'b1;
      @(negedge clk_tx);
      pulse_done_i = 1'b0;
   endtask

   // Six data fields, MSB nibble first; optionally drop enable in one of them.
   task automatic data_fields(input string tag, input logic [23:0] d, input int drop_idx);
      for (int i = 0; i < 6; i++) begin
         if (i == drop_idx) enable_i = 1'b0;
         field($sformatf("%s D%0d", tag, i), C_PULSE, d[23-4*i -: 4]);
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk_tx);
      chk("rst ctl", {28'h0, sync_o, pulse_o, pause_o, idle_o}, {28'h0, C_IDLE});
      chk("rst nib", {28'h0, data_nibble_o}, 32'h0);
      chk("rst crc", {28'h0, crc_o}, 32'h0);
      chk("rst rdy", {31'h0, data_ready_o}, 32'h0);
      chk("rst fdone", {31'h0, frame_done_o}, 32'h0);

      // Enable alone with nothing latched, plus a stray done, stays idle
      reset_tx = 1'b0;
      enable_i = 1'b1;
      pulse_done_i = 1'b1;
      @(negedge clk_tx);
      pulse_done_i = 1'b0;
      repeat (3) @(negedge clk_tx);
      chk("idle noframe", {28'h0, sync_o, pulse_o, pause_o, idle_o}, {28'h0, C_IDLE});

      // Frame 1: all-zero data
      data_i = 24'h000000; status_i = 4'h0; data_valid_i = 1'b1;
      @(negedge clk_tx);
      chk("F1 rdy", {31'h0, data_ready_o}, 32'h1);
      data_valid_i = 1'b0;
      field("F1 SYNC", C_SYNC, 4'h0);
      field("F1 STAT", C_PULSE, 4'h0);
      data_fields("F1", 24'h000000, -1);
      chk("F1 crc_o", {28'h0, crc_o}, 32'h5);
      data_i = 24'h123456; status_i = 4'hA; data_valid_i = 1'b1;   // offered mid-frame
      field("F1 CRC", C_PULSE, 4'h5);
`ifdef SENT_TX_PAUSE_EN
      field("F1 PAUSE", C_PAUSE, 4'h0);
`endif
      chk("F1 fdone", {31'h0, frame_done_o}, 32'h1);
      chk("F2 rdy", {31'h0, data_ready_o}, 32'h1);
      data_valid_i = 1'b0;

      // Frame 2: 123456 / status A, CRC = 2
      field("F2 SYNC", C_SYNC, 4'h0);
      field("F2 STAT", C_PULSE, 4'hA);
      data_fields("F2", 24'h123456, -1);
      chk("F2 crc_o", {28'h0, crc_o}, 32'h2);
      field("F2 CRC", C_PULSE, 4'h2);
`ifdef SENT_TX_PAUSE_EN
      field("F2 PAUSE", C_PAUSE, 4'h0);
`endif
      chk("F2 fdone", {31'h0, frame_done_o}, 32'h1);
      chk("F3 no rdy", {31'h0, data_ready_o}, 32'h0);

      // Frame 3: resend (back-to-back SYNC), enable dropped in DATA field 3
      field("F3 SYNC", C_SYNC, 4'h0);
      field("F3 STAT", C_PULSE, 4'hA);
      data_fields("F3", 24'h123456, 2);
      field("F3 CRC", C_PULSE, 4'h2);
`ifdef SENT_TX_PAUSE_EN
      field("F3 PAUSE", C_PAUSE, 4'h0);
`endif
      chk("F3 fdone", {31'h0, frame_done_o}, 32'h1);
      chk("F3 end ctl", {28'h0, sync_o, pulse_o, pause_o, idle_o}, {28'h0, C_IDLE});
      repeat (3) @(negedge clk_tx);
      chk("F3 idle ctl", {28'h0, sync_o, pulse_o, pause_o, idle_o}, {28'h0, C_IDLE});
      chk("F3 idle nib", {28'h0, data_nibble_o}, 32'h0);
      chk("rdy count", rdy_cnt, 32'd2);
      chk("fdone count", done_cnt, 32'd3);

      // Frame 4: resend from idle, reset asynchronously inside the CRC field
      enable_i = 1'b1;
      @(negedge clk_tx);
      chk("F4 no rdy", {31'h0, data_ready_o}, 32'h0);
      field("F4 SYNC", C_SYNC, 4'h0);
      field("F4 STAT", C_PULSE, 4'hA);
      data_fields("F4", 24'h123456, -1);
      chk("F4 CRC ctl", {28'h0, sync_o, pulse_o, pause_o, idle_o}, {28'h0, C_PULSE});
      repeat (3) @(negedge clk_tx);
      #2 reset_tx = 1'b1;
      #1;
      chk("arst ctl", {28'h0, sync_o, pulse_o, pause_o, idle_o}, {28'h0, C_IDLE});
      chk("arst nib", {28'h0, data_nibble_o}, 32'h0);
      chk("arst crc", {28'h0, crc_o}, 32'h0);
      @(negedge clk_tx);
      reset_tx = 1'b0;
      repeat (3) @(negedge clk_tx);
      chk("arst fdone count", done_cnt, 32'd3);
      chk("post rst idle", {28'h0, sync_o, pulse_o, pause_o, idle_o}, {28'h0, C_IDLE});
`ifdef SENT_TX_PAUSE_EN
      chk("pause cycles", pause_cnt, 32'd24);
`else
      chk("pause never", pause_cnt, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
